// File: rtl/mesh_switch_alloc.sv
// Switch allocator for the mesh router: per-output round-robin arbitration,
// wormhole locking for multi-flit packets and credit-based downstream flow control.
module mesh_switch_alloc #(
  parameter int N_PORTS = 5,
  parameter int CREDITS = 4,
  localparam int SEL_W = $clog2(N_PORTS),
  localparam int CNT_W = $clog2(CREDITS + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_PORTS-1:0]           i_req_val,
  input  logic [N_PORTS*N_PORTS-1:0]   i_output_req,
  input  logic [N_PORTS-1:0]           i_tail,
  input  logic [N_PORTS-1:0]           i_credit,
  output logic [N_PORTS-1:0]           o_grant,
  output logic [N_PORTS*SEL_W-1:0]     o_sel,
  output logic [N_PORTS-1:0]           o_val,
  output logic                         o_credit_err
);

  logic [N_PORTS-1:0]                  lock_vld;
  logic [N_PORTS-1:0][SEL_W-1:0]       lock_src;
  logic [N_PORTS-1:0][SEL_W-1:0]       rr_ptr;
  logic [N_PORTS-1:0][CNT_W-1:0]       credit;
  logic                                err;

  logic [N_PORTS-1:0][N_PORTS-1:0]     req;
  logic [N_PORTS-1:0]                  win;
  logic [N_PORTS-1:0][SEL_W-1:0]       win_src;
  logic [N_PORTS-1:0][SEL_W-1:0]       sel;
  logic [N_PORTS-1:0]                  grant;

  // req is output-major: req[j][i] = input i wants output j
  always_comb begin
    req = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      for (int j = 0; j < N_PORTS; j++) begin
        req[j][i] = i_req_val[i] & i_output_req[i*N_PORTS + j];
      end
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_src = '0;
    sel     = '0;
    grant   = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      if (lock_vld[j]) sel[j] = lock_src[j];
      if (credit[j] != '0) begin
        if (lock_vld[j]) begin
          if (req[j][lock_src[j]]) begin
            win[j]     = 1'b1;
            win_src[j] = lock_src[j];
          end
        end else begin
          // scan farthest-first so the candidate nearest rr_ptr is written last
          for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr[j]) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (req[j][idx]) begin
              win[j]     = 1'b1;
              win_src[j] = SEL_W'(idx);
            end
          end
        end
      end
      if (win[j]) begin
        sel[j]             = win_src[j];
        grant[win_src[j]]  = 1'b1;
      end
    end
  end

  assign o_grant      = reset_n ? grant : '0;
  assign o_val        = reset_n ? win   : '0;
  assign o_sel        = reset_n ? sel   : '0;
  assign o_credit_err = err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_vld <= '0;
      lock_src <= '0;
      rr_ptr   <= '0;
      credit   <= {N_PORTS{CNT_W'(CREDITS)}};
      err      <= 1'b0;
    end else begin
      for (int j = 0; j < N_PORTS; j++) begin
        if (win[j]) begin
          lock_vld[j] <= ~i_tail[win_src[j]];
          if (!i_tail[win_src[j]]) lock_src[j] <= win_src[j];
          // pointer only advances on packet heads
          if (!lock_vld[j]) begin
            rr_ptr[j] <= (win_src[j] == SEL_W'(N_PORTS - 1)) ? '0 : win_src[j] + 1'b1;
          end
        end
        if (win[j] && !i_credit[j]) begin
          credit[j] <= credit[j] - 1'b1;
        end else if (!win[j] && i_credit[j]) begin
          if (credit[j] == CNT_W'(CREDITS)) err <= 1'b1;
          else credit[j] <= credit[j] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mesh_switch_alloc.sv
// Self-checking bench for mesh_switch_alloc: expected grant/val/sel/err per cycle
// are queued as stimulus is applied and compared when the outputs settle.
module tb_mesh_switch_alloc;

  localparam int N = 5;
  localparam int SW = 3;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      req_val;
  logic [N*N-1:0]    oreq;
  logic [N-1:0]      tail;
  logic [N-1:0]      credit;
  logic [N-1:0]      o_grant;
  logic [N*SW-1:0]   o_sel;
  logic [N-1:0]      o_val;
  logic              o_credit_err;

  typedef struct packed {
    logic [N-1:0]    g;
    logic [N-1:0]    v;
    logic [N*SW-1:0] s;
    logic            e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  mesh_switch_alloc #(.N_PORTS(N), .CREDITS(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req_val   (req_val),
    .i_output_req(oreq),
    .i_tail      (tail),
    .i_credit    (credit),
    .o_grant     (o_grant),
    .o_sel       (o_sel),
    .o_val       (o_val),
    .o_credit_err(o_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*N-1:0] rq(input int i, input int o);
    logic [N*N-1:0] r;
    r = '0;
    r[i*N + o] = 1'b1;
    return r;
  endfunction

  function automatic logic [N*SW-1:0] sl(input int j, input int v);
    logic [N*SW-1:0] s;
    s = '0;
    s[j*SW +: SW] = SW'(v);
    return s;
  endfunction

  task automatic set_in(input logic [N-1:0] rv, input logic [N*N-1:0] oq,
                        input logic [N-1:0] tl, input logic [N-1:0] cr);
    req_val = rv;
    oreq    = oq;
    tail    = tl;
    credit  = cr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    set_in('0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // illegal stimulus guard: a valid request must be one-hot
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_val[i] && !$onehot(oreq[i*N +: N])) begin
          errors++;
          $display("FAIL illegal_req input %0d req %b required one-hot", i, oreq[i*N +: N]);
        end
      end
    end
  end

  task automatic test_reset();
    exp_t ex;
    reset_n = 1'b0;
    set_in(5'b00001, rq(0, 0), 5'b00001, 5'b00000);
    sb.push_back('{g: '0, v: '0, s: '0, e: 1'b0});
    #2;
    ex = sb.pop_front();
    checks++;
    if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
      errors++;
      $display("FAIL reset_hold grant %b/%b val %b/%b sel %h/%h err %b/%b",
               o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_in('0, '0, '0, '0);
    sb.push_back('{g: '0, v: '0, s: '0, e: 1'b0});
    #2;
    ex = sb.pop_front();
    checks++;
    if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
      errors++;
      $display("FAIL reset_idle grant %b/%b val %b/%b sel %h/%h err %b/%b",
               o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
    end
    next_cycle();
    // input 3 -> output 2, no credit returns: four sends then stall
    for (int k = 0; k < 6; k++) begin
      set_in(5'b01000, rq(3, 2), 5'b01000, 5'b00000);
      if (k < 4) sb.push_back('{g: 5'b01000, v: 5'b00100, s: sl(2, 3), e: 1'b0});
      else       sb.push_back('{g: '0, v: '0, s: '0, e: 1'b0});
      #2;
      ex = sb.pop_front();
      checks++;
      if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
        errors++;
        $display("FAIL credit_init cyc %0d grant %b/%b val %b/%b sel %h/%h err %b/%b",
                 k, o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    exp_t ex;
    int order[3] = '{0, 1, 3};
    int w;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      set_in(5'b01011, rq(0, 2) | rq(1, 2) | rq(3, 2), 5'b11111, 5'b00100);
      w = order[k % 3];
      sb.push_back('{g: N'(1 << w), v: 5'b00100, s: sl(2, w), e: 1'b0});
      #2;
      ex = sb.pop_front();
      checks++;
      if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
        errors++;
        $display("FAIL round_robin cyc %0d grant %b/%b val %b/%b sel %h/%h err %b/%b",
                 k, o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
      end
      next_cycle();
    end
  endtask

  task automatic test_wormhole();
    exp_t ex;
    logic [N-1:0]   rv_t[5] = '{5'b00010, 5'b00011, 5'b00011, 5'b00001, 5'b00001};
    logic [N*N-1:0] oq_t[5] = '{rq(1, 4), rq(1, 4) | rq(0, 4), rq(1, 4) | rq(0, 4),
                                rq(0, 4), rq(0, 4)};
    logic [N-1:0]   tl_t[5] = '{5'b00000, 5'b00001, 5'b00011, 5'b00001, 5'b00001};
    logic [N-1:0]   g_t[5]  = '{5'b00010, 5'b00010, 5'b00010, 5'b00001, 5'b00000};
    logic [N-1:0]   v_t[5]  = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00000};
    int             s_t[5]  = '{1, 1, 1, 0, 0};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(rv_t[k], oq_t[k], tl_t[k], 5'b00000);
      sb.push_back('{g: g_t[k], v: v_t[k], s: sl(4, s_t[k]), e: 1'b0});
      #2;
      ex = sb.pop_front();
      checks++;
      if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
        errors++;
        $display("FAIL wormhole cyc %0d grant %b/%b val %b/%b sel %h/%h err %b/%b",
                 k, o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
      end
      next_cycle();
    end
  endtask

  task automatic test_bubble_stall();
    exp_t ex;
    logic [N-1:0]   rv_t[11];
    logic [N*N-1:0] oq_t[11];
    logic [N-1:0]   tl_t[11];
    logic [N-1:0]   cr_t[11];
    logic [N-1:0]   g_t[11];
    int             s_t[11];
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      rv_t[k] = 5'b00101;
      oq_t[k] = rq(2, 1) | rq(0, 1);
      tl_t[k] = 5'b00001;
      cr_t[k] = 5'b00000;
      g_t[k]  = 5'b00000;
      s_t[k]  = 2;
    end
    rv_t[0] = 5'b00100; oq_t[0] = rq(2, 1); tl_t[0] = 5'b00000; g_t[0] = 5'b00100;
    rv_t[1] = 5'b00001; oq_t[1] = rq(0, 1);
    rv_t[2] = 5'b00001; oq_t[2] = rq(0, 1);
    g_t[3] = 5'b00100; g_t[4] = 5'b00100; g_t[5] = 5'b00100;
    tl_t[6] = 5'b00101; tl_t[7] = 5'b00101; tl_t[8] = 5'b00101;
    cr_t[7] = 5'b00010;
    g_t[8] = 5'b00100;
    rv_t[9]  = 5'b00001; oq_t[9]  = rq(0, 1); cr_t[9] = 5'b00010; s_t[9] = 0;
    rv_t[10] = 5'b00001; oq_t[10] = rq(0, 1); g_t[10] = 5'b00001; s_t[10] = 0;
    for (int k = 0; k < 11; k++) begin
      set_in(rv_t[k], oq_t[k], tl_t[k], cr_t[k]);
      sb.push_back('{g: g_t[k], v: (g_t[k] != '0) ? 5'b00010 : 5'b00000,
                     s: sl(1, s_t[k]), e: 1'b0});
      #2;
      ex = sb.pop_front();
      checks++;
      if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
        errors++;
        $display("FAIL bubble_stall cyc %0d grant %b/%b val %b/%b sel %h/%h err %b/%b",
                 k, o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
      end
      next_cycle();
    end
  endtask

  task automatic test_credit_accounting();
    exp_t ex;
    logic send_req, cr, granted, e;
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      send_req = (k <= 5) || (k >= 12);
      cr       = (k == 2) || (k >= 6 && k <= 10);
      granted  = (k <= 4) || (k >= 12 && k <= 15);
      e        = (k >= 11);
      set_in(send_req ? 5'b01000 : 5'b00000, send_req ? rq(3, 0) : '0,
             5'b01000, {4'b0000, cr});
      sb.push_back('{g: granted ? 5'b01000 : 5'b00000, v: granted ? 5'b00001 : 5'b00000,
                     s: granted ? sl(0, 3) : '0, e: e});
      #2;
      ex = sb.pop_front();
      checks++;
      if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
        errors++;
        $display("FAIL credit_acct cyc %0d grant %b/%b val %b/%b sel %h/%h err %b/%b",
                 k, o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    exp_t ex;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(5'b10000, rq(4, 3), 5'b00000, 5'b00000);
      sb.push_back('{g: 5'b10000, v: 5'b01000, s: sl(3, 4), e: 1'b0});
      #2;
      ex = sb.pop_front();
      checks++;
      if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
        errors++;
        $display("FAIL async_pre cyc %0d grant %b/%b val %b/%b sel %h/%h err %b/%b",
                 k, o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
      end
      if (k < 2) next_cycle();
    end
    #1;
    reset_n = 1'b0;
    sb.push_back('{g: '0, v: '0, s: '0, e: 1'b0});
    #1;
    ex = sb.pop_front();
    checks++;
    if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
      errors++;
      $display("FAIL async_drop grant %b/%b val %b/%b sel %h/%h err %b/%b",
               o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
    end
    next_cycle();
    reset_n = 1'b1;
    // lock gone and credits full: input 1 gets four grants, then stalls
    for (int k = 0; k < 5; k++) begin
      set_in(5'b00010, rq(1, 3), 5'b00010, 5'b00000);
      if (k < 4) sb.push_back('{g: 5'b00010, v: 5'b01000, s: sl(3, 1), e: 1'b0});
      else       sb.push_back('{g: '0, v: '0, s: '0, e: 1'b0});
      #2;
      ex = sb.pop_front();
      checks++;
      if (o_grant !== ex.g || o_val !== ex.v || o_sel !== ex.s || o_credit_err !== ex.e) begin
        errors++;
        $display("FAIL async_post cyc %0d grant %b/%b val %b/%b sel %h/%h err %b/%b",
                 k, o_grant, ex.g, o_val, ex.v, o_sel, ex.s, o_credit_err, ex.e);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    set_in('0, '0, '0, '0);
    test_reset();
    test_round_robin();
    test_wormhole();
    test_bubble_stall();
    test_credit_accounting();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_switch_alloc.md
Name: mesh_switch_alloc

Overview:
- Parametrised switch allocator for the mesh router: N_PORTS inputs/outputs, per-output round-robin arbitration, wormhole locking on multi-flit packets, and credit-based downstream flow control.
- Sits between the per-input FIFO/route-calculator pairs and the crossbar.
- Drives FIFO pops, crossbar selects and output valids.
- Supersedes the fixed 5-port enable-based switch control.

Parameters:
- N_PORTS, 5, number of router ports (index 0 = core, then north, east, south, west for the default).
- CREDITS, 4, downstream input-buffer depth; initial and maximum credit count per output.
- SEL_W, $clog2(N_PORTS), derived; crossbar select width per output.
- CNT_W, $clog2(CREDITS+1), derived; credit counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_req_val  input  N_PORTS  bit i: input FIFO i head flit valid.
- i_output_req  input  N_PORTS*N_PORTS  bits [i*N_PORTS +: N_PORTS]: one-hot output request of input i (bit j = output j).
- i_tail  input  N_PORTS  bit i: head flit of input i is the last flit of its packet (single-flit packet: tail=1).
- i_credit  input  N_PORTS  bit j: one-cycle pulse, downstream of output j freed one slot.
- o_grant  output  N_PORTS  bit i: pop input FIFO i this cycle.
- o_sel  output  N_PORTS*SEL_W  bits [j*SEL_W +: SEL_W]: input index routed to output j.
- o_val  output  N_PORTS  bit j: output j carries a valid flit this cycle.
- o_credit_err  output  1  sticky: a credit returned to a full counter.

Behaviour:
- State per output j: lock_vld[j], lock_src[j] (SEL_W), rr_ptr[j] (SEL_W), credit[j] (CNT_W); plus err flag.
- Reset (async, reset_n low): lock_vld=0, lock_src=0, rr_ptr=0, credit=CREDITS, err=0. While reset_n low, o_grant=0, o_val=0, o_sel=0, o_credit_err=0.
- Allocation is combinational from current state and inputs; zero-latency grant: o_grant, o_sel, o_val all valid in the same cycle as the request.
- Request r[i][j] = i_req_val[i] & i_output_req[i*N_PORTS+j]. An i_output_req that is not one-hot while i_req_val=1 is illegal; behaviour is undefined and the bench flags it.
- Output j is eligible only when credit[j] != 0.
- Unlocked eligible output: winner = first i with r[i][j]=1, searching from rr_ptr[j] upward, modulo N_PORTS.
- Locked eligible output: winner = lock_src[j] iff r[lock_src][j]=1. No other input may win. A bubble (locked source not valid) gives o_val[j]=0, and the lock is held.
- On a win: o_val[j]=1, o_sel[j]=winner, o_grant[winner]=1.
- With no win: o_val[j]=0, o_sel[j] holds lock_src[j] if locked, else 0.
- Clock-edge updates on a win at output j:
  - credit[j] decrements.
  - If i_tail[winner]=0: lock_vld=1, lock_src=winner. If i_tail=1: lock_vld=0.
  - If the output was unlocked (new packet head): rr_ptr[j] = winner+1 mod N_PORTS. rr_ptr is unchanged while locked.
- Credit accounting:
  - i_credit[j] alone: increment.
  - Send and i_credit[j] in the same cycle: unchanged.
  - i_credit[j] with credit[j]==CREDITS and no send: counter held at CREDITS, err set to 1; err clears only on reset.
- Credit exhaustion mid-packet: the lock is held, no grant, and the packet resumes when a credit returns.
- U-turns (input i requesting output i) are legal and arbitrated like any other request.
- Lock persists across any number of cycles; only a granted tail flit or reset releases it.

Test Plan:
- Reset then idle: after reset_n deasserts with no requests -> o_grant=0, o_val=0, every credit reads 4; 4 sends to output 2 with no returns, then a 5th request -> 5th not granted.
- Round-robin fairness: inputs 0, 1 and 3 each send continuous single-flit (tail=1) traffic to output 2, credits returned every cycle -> grant order 0, 1, 3, 0, 1, 3, with o_sel[2] following the same sequence.
- Wormhole lock: input 1 sends a 3-flit packet to output 4 (tail on flit 3) while input 0 requests output 4 from cycle 1 -> input 1 wins 3 consecutive grants, input 0 wins in the cycle after the tail.
- Bubble and credit stall mid-packet: input 2 head to output 1, then input 2 invalid for 2 cycles, and output 1 credits run to 0 -> o_val[1]=0 throughout, lock_src stays 2, no other input granted; one i_credit pulse -> input 2 resumes next cycle.
- Simultaneous send and credit return at output 0 with credit=2 -> credit stays 2. Credit pulse with credit=4 -> o_credit_err=1 and remains 1 until reset.
- Async reset mid-packet: assert reset_n low between clock edges while output 3 is locked -> o_val and o_grant drop to 0 immediately; after release, output 3 is unlocked and credits read 4.
